// File: rtl/robo_pkg.sv
// Shared constants for the robot sensor conditioning path: channel indices,
// channel count and the default debounce length (1 ms at 50 MHz).
package robo_pkg;

  typedef enum logic [1:0] {
    CH_A = 2'd0,
    CH_D = 2'd1,
    CH_F = 2'd2,
    CH_E = 2'd3
  } ch_idx_e;

  localparam int unsigned NUM_CH           = 4;
  localparam int unsigned DEBOUNCE_DEFAULT = 50000;

endpackage

// File: rtl/debounce_channel.sv
// One sensor channel: two-flop synchroniser, stability counter, output register.
// o_toggle flags the cycle on which o_level is about to change.
module debounce_channel
  import robo_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_toggle
);

  localparam int unsigned   CW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          w_diff;
  logic          w_done;

  assign w_diff = (r_sync2 != r_level);
  assign w_done = w_diff && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      // Any sample matching the current output restarts the stability window.
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level  = r_level;
  assign o_toggle = w_done;

endmodule

// File: rtl/sensor_debounce.sv
// Debounces the four raw robot sensor pins into SenE/SenF/SenD/SenA with a
// post-reset validity flag. Define SENSOR_EVT_EN to add the sens_evt pulse port.
module sensor_debounce
  import robo_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              raw_e,
  input  logic              raw_f,
  input  logic              raw_d,
  input  logic              raw_a,
  output logic              SenE,
  output logic              SenF,
  output logic              SenD,
  output logic              SenA,
`ifdef SENSOR_EVT_EN
  output logic [NUM_CH-1:0] sens_evt,
`endif
  output logic              sens_valid
);

  localparam int unsigned   WW        = $clog2(DEBOUNCE_CYCLES + 2) + 1;
  localparam logic [WW-1:0] WARM_LAST = WW'(DEBOUNCE_CYCLES + 1);

  logic [NUM_CH-1:0] w_raw;
  logic [NUM_CH-1:0] w_lvl;
  logic [NUM_CH-1:0] w_tgl;
  logic [WW-1:0]     r_warm;
  logic              r_valid;

  assign w_raw[CH_E] = raw_e;
  assign w_raw[CH_F] = raw_f;
  assign w_raw[CH_D] = raw_d;
  assign w_raw[CH_A] = raw_a;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_raw   (w_raw[g]),
      .o_level (w_lvl[g]),
      .o_toggle(w_tgl[g])
    );
  end

  // Warm-up counter freezes once valid is set; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_warm  <= '0;
      r_valid <= 1'b0;
    end else if (!r_valid) begin
      if (r_warm == WARM_LAST) begin
        r_valid <= 1'b1;
      end else begin
        r_warm <= r_warm + WW'(1);
      end
    end
  end

`ifdef SENSOR_EVT_EN
  logic [NUM_CH-1:0] r_evt;

  // Registering the channel's toggle strobe equals next-level XOR current-level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evt <= '0;
    end else begin
      r_evt <= r_valid ? w_tgl : '0;
    end
  end

  assign sens_evt = r_evt;
`else
  logic w_unused_tgl;
  assign w_unused_tgl = ^w_tgl;
`endif

  assign SenE       = w_lvl[CH_E];
  assign SenF       = w_lvl[CH_F];
  assign SenD       = w_lvl[CH_D];
  assign SenA       = w_lvl[CH_A];
  assign sens_valid = r_valid;

endmodule
